// File: rtl/sat_verify.sv
// sat_verify: checks a candidate assignment against M stored CNF clauses, one clause per cycle.
// Define SAT_VERIFY_UNSAT_COUNT_EN to always scan all clauses and report the unsatisfied count.
module sat_verify #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int IW = $clog2(M),
  localparam int CW = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clause_we,
  input  logic [IW-1:0] clause_addr,
  input  logic [N-1:0]  clause_pos,
  input  logic [N-1:0]  clause_neg,
  input  logic          cand_valid,
  output logic          cand_ready,
  input  logic [N-1:0]  cand,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_sat,
  output logic [IW-1:0] res_idx,
  output logic [CW-1:0] res_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  state_t        r_state;
  logic [N-1:0]  r_pos [M];
  logic [N-1:0]  r_neg [M];
  logic [N-1:0]  r_cand;
  logic [IW-1:0] r_idx;
  logic          r_sat;
  logic [IW-1:0] r_res_idx;
  logic          w_sat;
  logic          w_last;
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_res_cnt;
  logic [IW-1:0] r_first;
  logic          r_found;
  assign res_cnt = r_res_cnt;
`else
  assign res_cnt = '0;
`endif
  assign w_sat      = |(r_pos[r_idx] & r_cand) | |(r_neg[r_idx] & ~r_cand);
  assign w_last     = r_idx == IW'(M - 1);
  assign cand_ready = r_state == IDLE;
  assign res_valid  = r_state == REPORT;
  assign res_sat    = r_sat;
  assign res_idx    = r_res_idx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_idx     <= '0;
      r_sat     <= 1'b0;
      r_res_idx <= '0;
      for (int i = 0; i < M; i++) begin
        r_pos[i] <= '0;
        r_neg[i] <= '0;
      end
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
      r_cnt     <= '0;
      r_res_cnt <= '0;
      r_first   <= '0;
      r_found   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (clause_we) begin
            r_pos[clause_addr] <= clause_pos;
            r_neg[clause_addr] <= clause_neg;
          end
          if (cand_valid) begin
            r_cand  <= cand;
            r_idx   <= '0;
            r_state <= SCAN;
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
            r_cnt   <= '0;
            r_found <= 1'b0;
`endif
          end
        end
        SCAN: begin
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
          r_cnt <= r_cnt + CW'(!w_sat);
          if (!w_sat && !r_found) begin
            r_first <= r_idx;
            r_found <= 1'b1;
          end
          if (w_last) begin
            r_state   <= REPORT;
            r_sat     <= !r_found && w_sat;
            r_res_idx <= r_found ? r_first : (w_sat ? '0 : r_idx);
            r_res_cnt <= r_cnt + CW'(!w_sat);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
`else
          // early exit on the first unsatisfied clause
          if (!w_sat || w_last) begin
            r_state   <= REPORT;
            r_sat     <= w_sat;
            r_res_idx <= w_sat ? '0 : r_idx;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
`endif
        end
        REPORT: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sat_verify.sv
// tb_sat_verify: table, directed and randomized checks of sat_verify (N=4, M=4) against a clause-list model.
module tb_sat_verify;
  localparam int N = 4;
  localparam int M = 4;
  logic clk = 0;
  logic reset = 1;
  logic clause_we = 0;
  logic [1:0] clause_addr = 0;
  logic [N-1:0] clause_pos = 0, clause_neg = 0;
  logic cand_valid = 0;
  logic cand_ready;
  logic [N-1:0] cand = 0;
  logic res_valid;
  logic res_ready = 0;
  logic res_sat;
  logic [1:0] res_idx;
  logic [2:0] res_cnt;
  int n_tests = 0;
  int n_fail = 0;
  logic [N-1:0] mp [M];
  logic [N-1:0] mn [M];
  typedef struct {logic sat; int idx; int cnt; int lat;} res_t;
  typedef struct {logic [N-1:0] c; logic sat; int idx; int ucnt;} vec_t;
  vec_t tbl [5];

  sat_verify #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .clause_we(clause_we), .clause_addr(clause_addr),
    .clause_pos(clause_pos), .clause_neg(clause_neg), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .cand(cand), .res_valid(res_valid), .res_ready(res_ready),
    .res_sat(res_sat), .res_idx(res_idx), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int ucnt);
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
    return ucnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_lat(input logic sat, input int idx);
`ifdef SAT_VERIFY_UNSAT_COUNT_EN
    return M;
`else
    return sat ? M : idx + 1;
`endif
  endfunction

  function automatic res_t model(input logic [N-1:0] c);
    res_t r;
    int u[$];
    for (int i = 0; i < M; i++)
      if (!((|(mp[i] & c)) || (|(mn[i] & ~c)))) u.push_back(i);
    r.sat = u.size() == 0;
    r.idx = r.sat ? 0 : u[0];
    r.cnt = exp_cnt(u.size());
    r.lat = exp_lat(r.sat, r.idx);
    return r;
  endfunction

  task automatic cmp(input string nm, input res_t a, input res_t e);
    chk({nm, ".sat"}, a.sat, e.sat);
    chk({nm, ".idx"}, a.idx, e.idx);
    chk({nm, ".cnt"}, a.cnt, e.cnt);
    chk({nm, ".lat"}, a.lat, e.lat);
  endtask

  task automatic load(input int i, input logic [N-1:0] p, input logic [N-1:0] n);
    clause_we = 1; clause_addr = 2'(i); clause_pos = p; clause_neg = n;
    @(posedge clk); #1 clause_we = 0;
    mp[i] = p; mn[i] = n;
  endtask

  task automatic load_spec();
    for (int i = 0; i < M; i++) load(i, 4'(1 << i), 4'(1 << ((i + 3) % 4)));
  endtask

  task automatic run(input logic [N-1:0] c, input bit we_dur, output res_t r);
    chk("cand_ready_idle", cand_ready, 1);
    cand = c; cand_valid = 1;
    @(posedge clk); #1 cand_valid = 0;
    if (we_dur) begin
      clause_we = 1; clause_addr = 0; clause_pos = 4'hF; clause_neg = 4'hF;
    end
    r.lat = 0;
    while (!res_valid && r.lat < 20) begin
      @(posedge clk); #1 r.lat++;
    end
    clause_we = 0;
    r.sat = res_sat; r.idx = res_idx; r.cnt = res_cnt;
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
  endtask

  initial begin
    res_t r, e;
    int k;
    for (int i = 0; i < M; i++) begin mp[i] = 0; mn[i] = 0; end
    tbl[0] = '{4'b1111, 1'b1, 0, 0};
    tbl[1] = '{4'b0001, 1'b0, 1, 1};
    tbl[2] = '{4'b0101, 1'b0, 1, 2};
    tbl[3] = '{4'b0000, 1'b1, 0, 0};
    tbl[4] = '{4'b1010, 1'b0, 0, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_sat", res_sat, 0);
    chk("rst.res_idx", res_idx, 0);
    chk("rst.res_cnt", res_cnt, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("rst.cand_ready", cand_ready, 1);
    // unloaded memory, with writes attempted during SCAN/REPORT
    run(4'hF, 1, r); cmp("empty", r, model(4'hF));
    chk("empty.idx0", r.idx, 0);
    run(4'hF, 0, r); cmp("we_dropped", r, model(4'hF));
    load_spec();
    foreach (tbl[i]) begin
      run(tbl[i].c, 0, r);
      e.sat = tbl[i].sat; e.idx = tbl[i].idx;
      e.cnt = exp_cnt(tbl[i].ucnt); e.lat = exp_lat(tbl[i].sat, tbl[i].idx);
      cmp($sformatf("tbl%0d", i), r, e);
    end
    // stall in REPORT with a candidate waiting
    cand = 4'b0101; cand_valid = 1;
    @(posedge clk); #1 cand_valid = 0;
    k = 0;
    while (!res_valid && k < 20) begin @(posedge clk); #1 k++; end
    e = model(4'b0101);
    chk("hold.lat", k, e.lat);
    cand = 4'hF; cand_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold.res_valid", res_valid, 1);
      chk("hold.cand_ready", cand_ready, 0);
      chk("hold.sat", res_sat, e.sat);
      chk("hold.idx", res_idx, e.idx);
      chk("hold.cnt", res_cnt, e.cnt);
    end
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    chk("bubble.res_valid", res_valid, 0);
    chk("bubble.cand_ready", cand_ready, 1);
    cand_valid = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0)
        for (int i = 0; i < M; i++)
          if ($urandom_range(3) == 0) load(i, 0, 0);
          else load(i, 4'($urandom), 4'($urandom));
      cand = 4'($urandom);
      e = model(cand);
      run(cand, 0, r); cmp($sformatf("rnd%0d", t), r, e);
    end
    // reset asserted on the second SCAN edge
    load_spec();
    cand = 4'hF; cand_valid = 1;
    @(posedge clk); #1 cand_valid = 0;
    @(posedge clk);
    @(posedge clk);
    reset = 1;
    #1;
    chk("midrst.res_valid", res_valid, 0);
    chk("midrst.res_sat", res_sat, 0);
    #10 reset = 0;
    for (int i = 0; i < M; i++) begin mp[i] = 0; mn[i] = 0; end
    @(posedge clk); #1;
    chk("midrst.cand_ready", cand_ready, 1);
    run(4'hF, 0, r); cmp("post_rst_empty", r, model(4'hF));
    load_spec();
    run(4'hF, 0, r); cmp("post_rst_sat", r, model(4'hF));
    chk("post_rst_sat.is_sat", r.sat, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
